frame_capture_ctrl: RTL and testbench

FRAME_CAPTURE_CTRL -- requirements
Module: frame_capture_ctrl

---
 rtl/video_ctrl_pkg.sv | 30 +++
 rtl/frame_size_check.sv | 41 ++++
 rtl/frame_capture_ctrl.sv | 156 +++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the frame capture controller.
// FRAME_CHECK_EN adds the FLUSH state used after a malformed frame.
package video_ctrl_pkg;

    localparam int DATA_W       = 24;
    localparam int DEF_WIDTH    = 640;
    localparam int DEF_HEIGHT   = 480;
    localparam int FRAME_PIXELS = DEF_WIDTH * DEF_HEIGHT;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PASS,
        DONE
`ifdef FRAME_CHECK_EN
        ,
        FLUSH
`endif
    } cap_state_e;

    function automatic int frame_pixels(input int w, input int h);
        return w * h;
    endfunction

    // Bits needed to hold the values 0..n inclusive.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/frame_size_check.sv
// Counts the beats of a frame after its startofpacket beat and flags a
// length other than WIDTH*HEIGHT when the endofpacket beat is accepted.
module frame_size_check
    import video_ctrl_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int HEIGHT = DEF_HEIGHT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sop_beat,
    input  logic body_beat,
    input  logic eop_beat,
    output logic size_err
);

    localparam int PIXELS = frame_pixels(WIDTH, HEIGHT);
    localparam int CW     = cnt_width(PIXELS);
    localparam logic [CW-1:0] CNT_MAX = CW'(PIXELS);

    logic [CW-1:0] beat_cnt;
    logic [CW-1:0] cnt_base;
    logic [CW:0]   cnt_total;

    // The eop beat itself is part of the count, so judge the total including it.
    assign cnt_base  = sop_beat ? '0 : beat_cnt;
    assign cnt_total = {1'b0, cnt_base} + {{CW{1'b0}}, body_beat};
    assign size_err  = eop_beat && (cnt_total != {1'b0, CNT_MAX});

    // Saturating at PIXELS still yields a mismatch for any longer frame.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            beat_cnt <= '0;
        end else if (sop_beat) begin
            beat_cnt <= '0;
        end else if (body_beat && (beat_cnt != CNT_MAX)) begin
            beat_cnt <= beat_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/frame_capture_ctrl.sv
// Frame capture controller: gates an Avalon-ST video stream to whole frames.
// Define FRAME_CHECK_EN to add frame-size checking with a stream-reset flush.
module frame_capture_ctrl
    import video_ctrl_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int HEIGHT        = DEF_HEIGHT,
    parameter int SRESET_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] snk_data,
    input  logic              snk_valid,
    input  logic              snk_startofpacket,
    input  logic              snk_endofpacket,
    output logic              snk_ready,
    output logic [DATA_W-1:0] src_data,
    output logic              src_valid,
    output logic              src_startofpacket,
    output logic              src_endofpacket,
    input  logic              src_ready,
    input  logic              capture_req,
    input  logic              continuous,
    output logic              frame_transition,
    output logic              sreset,
    output logic              busy,
    output logic              frame_err,
    output logic [15:0]       frame_count
);

    cap_state_e  state;
    cap_state_e  state_nxt;
    logic        pending;
    logic [15:0] frame_count_q;
    logic        sop_take;
    logic        pass_take;
    logic        eop_take;

    assign sop_take  = (state == ARM) && snk_valid && snk_startofpacket && src_ready;
    assign pass_take = (state == PASS) && snk_valid && src_ready;
    assign eop_take  = (sop_take || pass_take) && snk_endofpacket;

`ifdef FRAME_CHECK_EN
    localparam int FCW = cnt_width(SRESET_CYCLES);
    localparam logic [FCW-1:0] FLUSH_LAST = FCW'(SRESET_CYCLES - 1);

    logic           size_err;
    logic           frame_bad;
    logic           frame_err_q;
    logic [FCW-1:0] flush_cnt;

    frame_size_check #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_size_check (
        .clk       (clk),
        .reset_n   (reset_n),
        .sop_beat  (sop_take),
        .body_beat (pass_take),
        .eop_beat  (eop_take),
        .size_err  (size_err)
    );

    assign frame_bad = size_err || (pass_take && snk_startofpacket);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_q <= 1'b0;
            flush_cnt   <= '0;
        end else begin
            if ((state_nxt == FLUSH) && (state != FLUSH)) begin
                frame_err_q <= 1'b1;
            end else if (capture_req) begin
                frame_err_q <= 1'b0;
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + FCW'(1) : '0;
        end
    end

    assign sreset    = (state == FLUSH);
    assign frame_err = frame_err_q;
`else
    assign sreset    = 1'b0;
    assign frame_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (capture_req || continuous) state_nxt = ARM;
            ARM, PASS: begin
                if (sop_take) state_nxt = PASS;
                if (eop_take) state_nxt = DONE;
`ifdef FRAME_CHECK_EN
                if (frame_bad) state_nxt = FLUSH;
`endif
            end
            DONE: state_nxt = (continuous || pending || capture_req) ? ARM : IDLE;
`ifdef FRAME_CHECK_EN
            FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = IDLE;
`endif
            default: state_nxt = IDLE;
        endcase
    end

    // Only sop beats are offered downstream while armed; everything else is dropped.
    always_comb begin
        src_valid = 1'b0;
        snk_ready = 1'b1;
        case (state)
            ARM: begin
                src_valid = snk_valid && snk_startofpacket;
                snk_ready = snk_startofpacket ? src_ready : 1'b1;
            end
            PASS: begin
                src_valid = snk_valid;
                snk_ready = src_ready;
            end
            DONE:    snk_ready = 1'b0;
            default: ;
        endcase
    end

    assign src_data          = snk_data;
    assign src_startofpacket = snk_startofpacket;
    assign src_endofpacket   = snk_endofpacket;
    assign busy              = (state != IDLE);
    assign frame_transition  = (state == DONE);
    assign frame_count       = frame_count_q;

    // A request is remembered once; entering ARM consumes it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending       <= 1'b0;
            frame_count_q <= '0;
        end else begin
            if ((state_nxt == ARM) && (state != ARM)) begin
                pending <= 1'b0;
            end else if (capture_req && ((state == ARM) || (state == PASS) || (state == DONE))) begin
                pending <= 1'b1;
            end
            if (state == DONE) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Randomized bench for frame_capture_ctrl against a frame-level reference model.
// Honours FRAME_CHECK_EN when the design is built with it.
`timescale 1ns/1ps
module tb_frame_capture_ctrl;

    localparam int W   = 4;
    localparam int H   = 2;
    localparam int SRC = 4;
    localparam int PIX = W * H;

    typedef struct packed {
        logic [23:0] d;
        logic        s;
        logic        e;
    } beat_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [23:0] snk_data;
    logic        snk_valid, snk_startofpacket, snk_endofpacket, snk_ready;
    logic [23:0] src_data;
    logic        src_valid, src_startofpacket, src_endofpacket, src_ready;
    logic        capture_req, continuous;
    logic        frame_transition, sreset, busy, frame_err;
    logic [15:0] frame_count;

    int    checks = 0;
    int    errors = 0;
    beat_t in_q[$];
    beat_t exp_q[$];
    beat_t got_q[$];
    int    ft_cnt, sr_cnt, mir_n, mir_bad, idle_seen;
    bit    toggle_en = 1'b0;
    bit    track_busy = 1'b0;
    int    exp_count = 0;

    frame_capture_ctrl #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .SRESET_CYCLES (SRC)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .snk_data          (snk_data),
        .snk_valid         (snk_valid),
        .snk_startofpacket (snk_startofpacket),
        .snk_endofpacket   (snk_endofpacket),
        .snk_ready         (snk_ready),
        .src_data          (src_data),
        .src_valid         (src_valid),
        .src_startofpacket (src_startofpacket),
        .src_endofpacket   (src_endofpacket),
        .src_ready         (src_ready),
        .capture_req       (capture_req),
        .continuous        (continuous),
        .frame_transition  (frame_transition),
        .sreset            (sreset),
        .busy              (busy),
        .frame_err         (frame_err),
        .frame_count       (frame_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (toggle_en) begin
            #1 src_ready = ~src_ready;
        end
    end

    always @(negedge clk) begin
        if (src_valid && src_ready) got_q.push_back('{src_data, src_startofpacket, src_endofpacket});
        if (frame_transition) ft_cnt++;
        if (sreset) sr_cnt++;
        if (src_valid) begin
            mir_n++;
            if (snk_ready !== src_ready) mir_bad++;
        end
        if (track_busy && busy !== 1'b1) idle_seen++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic clear_obs();
        got_q.delete();
        in_q.delete();
        ft_cnt = 0; sr_cnt = 0; mir_n = 0; mir_bad = 0; idle_seen = 0;
    endtask

    task automatic add_pkt(input int n);
        for (int i = 0; i < n; i++) in_q.push_back('{24'($urandom), (i == 0), (i == n - 1)});
    endtask

    task automatic add_garbage(input int n);
        for (int i = 0; i < n; i++) in_q.push_back('{24'($urandom), 1'b0, 1'b0});
    endtask

    // Frame-level model: beats from each sop through its eop are forwarded,
    // everything outside a frame is dropped, capture stops after max_frames.
    task automatic run_model(input int max_frames, output int nframes);
        bit inp = 1'b0;
        nframes = 0;
        exp_q.delete();
        foreach (in_q[i]) begin
            if (nframes >= max_frames) break;
            if (!inp) begin
                if (in_q[i].s) begin
                    exp_q.push_back(in_q[i]);
                    if (in_q[i].e) nframes++;
                    else inp = 1'b1;
                end
            end else begin
                exp_q.push_back(in_q[i]);
                if (in_q[i].e) begin
                    inp = 1'b0;
                    nframes++;
                end
            end
        end
    endtask

    task automatic settle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_req();
        capture_req = 1'b1;
        @(posedge clk);
        #1 capture_req = 1'b0;
    endtask

    task automatic drive(input int req_a, input int req_b, input int cont_off, input bit gaps);
        for (int i = 0; i < in_q.size(); i++) begin
            int n;
            if (gaps && $urandom_range(0, 2) == 0) begin
                snk_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            snk_data          = in_q[i].d;
            snk_startofpacket = in_q[i].s;
            snk_endofpacket   = in_q[i].e;
            snk_valid         = 1'b1;
            capture_req       = (i == req_a) || (i == req_b);
            if (i == cont_off) continuous = 1'b0;
            n = 0;
            @(negedge clk);
            while (!snk_ready && n < 200) begin
                @(negedge clk);
                n++;
            end
            if (!snk_ready) begin
                checks++;
                errors++;
                $display("FAIL drive_timeout beat %0d: snk_ready=%b, required 1", i, snk_ready);
                snk_valid   = 1'b0;
                capture_req = 1'b0;
                return;
            end
            @(posedge clk);
            #1 capture_req = 1'b0;
        end
        snk_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (src_valid !== 1'b0)        begin errors++; $display("FAIL rst_src_valid got %b, required 0", src_valid); end
        checks++; if (snk_ready !== 1'b1)        begin errors++; $display("FAIL rst_snk_ready got %b, required 1", snk_ready); end
        checks++; if (busy !== 1'b0)             begin errors++; $display("FAIL rst_busy got %b, required 0", busy); end
        checks++; if (frame_transition !== 1'b0) begin errors++; $display("FAIL rst_ft got %b, required 0", frame_transition); end
        checks++; if (sreset !== 1'b0)           begin errors++; $display("FAIL rst_sreset got %b, required 0", sreset); end
        checks++; if (frame_err !== 1'b0)        begin errors++; $display("FAIL rst_frame_err got %b, required 0", frame_err); end
        checks++; if (frame_count !== 16'd0)     begin errors++; $display("FAIL rst_count got %0d, required 0", frame_count); end
        #2 reset_n = 1'b1;
        settle(2);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got %b, required 0", busy); end
        exp_count = 0;
    endtask

    task automatic test_single();
        int nf;
        clear_obs();
        add_garbage(3);
        add_pkt(PIX + 1);
        add_garbage(2);
        run_model(1, nf);
        pulse_req();
        drive(-1, -1, -1, 1'b0);
        settle(6);
        exp_count = (exp_count + nf) % 65536;
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_len got %0d beats, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_beat%0d got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ft_cnt !== nf)            begin errors++; $display("FAIL single_ft got %0d pulses, required %0d", ft_cnt, nf); end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL single_count got %0d, required %0d", frame_count, exp_count); end
        checks++; if (busy !== 1'b0)             begin errors++; $display("FAIL single_idle busy got %b, required 0", busy); end
    endtask

    task automatic test_continuous();
        int nf;
        clear_obs();
        add_pkt(PIX + 1);
        add_pkt(PIX + 1);
        add_pkt(PIX + 1);
        run_model(3, nf);
        continuous = 1'b1;
        settle(1);
        track_busy = 1'b1;
        drive(-1, -1, 2 * (PIX + 1) + 4, 1'b0);
        track_busy = 1'b0;
        settle(6);
        exp_count = (exp_count + nf) % 65536;
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL cont_len got %0d beats, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL cont_beat%0d got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ft_cnt !== 3)              begin errors++; $display("FAIL cont_ft got %0d pulses, required 3", ft_cnt); end
        checks++; if (idle_seen !== 0)           begin errors++; $display("FAIL cont_busy idle cycles %0d, required 0", idle_seen); end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL cont_count got %0d, required %0d", frame_count, exp_count); end
        checks++; if (busy !== 1'b0)             begin errors++; $display("FAIL cont_stop busy got %b, required 0", busy); end
    endtask

    task automatic test_pending();
        int nf;
        clear_obs();
        add_pkt(PIX + 1);
        add_pkt(PIX + 1);
        add_pkt(PIX + 1);
        run_model(2, nf);
        pulse_req();
        drive(3, 6, -1, 1'b1);
        settle(6);
        exp_count = (exp_count + nf) % 65536;
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL pend_len got %0d beats, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL pend_beat%0d got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (ft_cnt !== 2)              begin errors++; $display("FAIL pend_ft got %0d pulses, required 2", ft_cnt); end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL pend_count got %0d, required %0d", frame_count, exp_count); end
    endtask

    task automatic test_backpressure();
        int nf;
        clear_obs();
        add_garbage(2);
        add_pkt(PIX + 1);
        run_model(1, nf);
        pulse_req();
        toggle_en = 1'b1;
        drive(-1, -1, -1, 1'b1);
        toggle_en = 1'b0;
        settle(2);
        src_ready = 1'b1;
        settle(4);
        exp_count = (exp_count + nf) % 65536;
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL bp_len got %0d beats, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_beat%0d got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (mir_bad !== 0) begin errors++; $display("FAIL bp_mirror got %0d mismatched cycles, required 0", mir_bad); end
        checks++; if (mir_n < exp_q.size()) begin errors++; $display("FAIL bp_offers got %0d offered cycles, required >= %0d", mir_n, exp_q.size()); end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL bp_count got %0d, required %0d", frame_count, exp_count); end
    endtask

    task automatic test_size_err();
        int nf;
        clear_obs();
        add_pkt(PIX - 1);
        run_model(1, nf);
        pulse_req();
        drive(-1, -1, -1, 1'b0);
        settle(10);
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL size_len got %0d beats, required %0d", got_q.size(), exp_q.size()); end
`ifdef FRAME_CHECK_EN
        checks++; if (frame_err !== 1'b1)        begin errors++; $display("FAIL size_err got %b, required 1", frame_err); end
        checks++; if (sr_cnt !== SRC)            begin errors++; $display("FAIL size_sreset got %0d cycles, required %0d", sr_cnt, SRC); end
        checks++; if (ft_cnt !== 0)              begin errors++; $display("FAIL size_ft got %0d pulses, required 0", ft_cnt); end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL size_count got %0d, required %0d", frame_count, exp_count); end
        checks++; if (busy !== 1'b0)             begin errors++; $display("FAIL size_idle busy got %b, required 0", busy); end
        pulse_req();
        @(negedge clk);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL size_err_clear got %b, required 0", frame_err); end
        clear_obs();
        add_pkt(PIX + 1);
        drive(-1, -1, -1, 1'b0);
        settle(6);
        exp_count = (exp_count + 1) % 65536;
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL size_recover got %0d, required %0d", frame_count, exp_count); end
`else
        exp_count = (exp_count + nf) % 65536;
        checks++; if (frame_err !== 1'b0)        begin errors++; $display("FAIL size_err got %b, required 0", frame_err); end
        checks++; if (sr_cnt !== 0)              begin errors++; $display("FAIL size_sreset got %0d cycles, required 0", sr_cnt); end
        checks++; if (ft_cnt !== 1)              begin errors++; $display("FAIL size_ft got %0d pulses, required 1", ft_cnt); end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL size_count got %0d, required %0d", frame_count, exp_count); end
`endif
    endtask

    task automatic test_reset_mid();
        int nf;
        clear_obs();
        add_pkt(PIX + 1);
        void'(in_q.pop_back());
        void'(in_q.pop_back());
        void'(in_q.pop_back());
        void'(in_q.pop_back());
        pulse_req();
        drive(-1, -1, -1, 1'b0);
        snk_data = 24'($urandom);
        snk_startofpacket = 1'b0;
        snk_endofpacket = 1'b0;
        snk_valid = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0)             begin errors++; $display("FAIL mid_busy got %b, required 0", busy); end
        checks++; if (src_valid !== 1'b0)        begin errors++; $display("FAIL mid_src_valid got %b, required 0", src_valid); end
        checks++; if (snk_ready !== 1'b1)        begin errors++; $display("FAIL mid_snk_ready got %b, required 1", snk_ready); end
        checks++; if (frame_count !== 16'd0)     begin errors++; $display("FAIL mid_count got %0d, required 0", frame_count); end
        checks++; if (frame_transition !== 1'b0) begin errors++; $display("FAIL mid_ft got %b, required 0", frame_transition); end
        snk_valid = 1'b0;
        #3 reset_n = 1'b1;
        exp_count = 0;
        settle(2);
        clear_obs();
        add_garbage(1);
        add_pkt(PIX + 1);
        run_model(1, nf);
        pulse_req();
        drive(-1, -1, -1, 1'b1);
        settle(6);
        exp_count = (exp_count + nf) % 65536;
        checks++;
        if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL mid_len got %0d beats, required %0d", got_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_beat%0d got %h, required %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL mid_recount got %0d, required %0d", frame_count, exp_count); end
    endtask

    task automatic test_wrap();
        int nf;
        force dut.frame_count_q = 16'hFFFF;
        @(posedge clk);
        #1 release dut.frame_count_q;
        exp_count = 16'hFFFF;
        settle(1);
        clear_obs();
        add_pkt(PIX + 1);
        run_model(1, nf);
        pulse_req();
        drive(-1, -1, -1, 1'b0);
        settle(6);
        exp_count = (exp_count + nf) % 65536;
        checks++; if (frame_count !== exp_count) begin errors++; $display("FAIL wrap_count got %0d, required %0d", frame_count, exp_count); end
        checks++; if (ft_cnt !== 1)              begin errors++; $display("FAIL wrap_ft got %0d pulses, required 1", ft_cnt); end
    endtask

    initial begin
        reset_n           = 1'b0;
        snk_data          = '0;
        snk_valid         = 1'b0;
        snk_startofpacket = 1'b0;
        snk_endofpacket   = 1'b0;
        src_ready         = 1'b1;
        capture_req       = 1'b0;
        continuous        = 1'b0;
        test_reset();
        test_single();
        test_continuous();
        test_pending();
        test_backpressure();
        test_size_err();
        test_reset_mid();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
